// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin, hold-limited grant arbiter driving 4:1 priority mux selects
// At most one select is asserted, so the mux's own priority never chooses the winner.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       busy,
  output logic [3:0] hold_cnt
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner;
  logic [2:0] first_hit;
  logic [2:0] next_hit;

  // Returns {found, index} of the first set bit of r scanning upward from start with wrap.
  function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    owner = 2'd0;
    case (gnt_q)
      4'b0010: owner = 2'd1;
      4'b0100: owner = 2'd2;
      4'b1000: owner = 2'd3;
      default: owner = 2'd0;
    endcase
  end

  assign first_hit = search(req, ptr_q);
  // The owner is masked out, so rotation can only land on a different requester.
  assign next_hit  = search(req & ~gnt_q, owner + 2'd1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (first_hit[2]) begin
          gnt_d   = 4'b0001 << first_hit[1:0];
          hold_d  = 4'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!req[owner]) begin
          gnt_d   = 4'b0000;
          ptr_d   = owner + 2'd1;
          hold_d  = 4'd0;
          state_d = IDLE;
        end else if (hold_q < HOLD_LAST) begin
          hold_d = hold_q + 4'd1;
        end else if (next_hit[2]) begin
          gnt_d  = 4'b0001 << next_hit[1:0];
          ptr_d  = next_hit[1:0] + 2'd1;
          hold_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        hold_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      hold_q  <= 4'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign s1       = (gnt_q == 4'b0010);
  assign s2       = (gnt_q == 4'b0100);
  assign s3       = (gnt_q == 4'b1000);
  assign busy     = |gnt_q;
  assign hold_cnt = hold_q;

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation when others wait (legal 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: req  input  4  request per source; bit i = mux data input i (0=A, 1=B, 2=C, 3=D).
REQ-005 Port: gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-006 Port: s1  output  1  mux select for input B; high only when gnt==4'b0010.
REQ-007 Port: s2  output  1  mux select for input C; high only when gnt==4'b0100.
REQ-008 Port: s3  output  1  mux select for input D; high only when gnt==4'b1000.
REQ-009 Port: busy  output  1  high whenever gnt is non-zero.
REQ-010 Port: hold_cnt  output  4  cycles the current owner has held the grant, minus one; 0 when idle.

Function
REQ-011 Block SHALL time-share the 4:1 priority select mux among four requesters by driving s1/s2/s3 such that at most one select is high, so mux priority never decides the winner.
REQ-012 s1, s2, s3, busy SHALL be decoded combinationally from registered gnt; gnt==4'b0001 or 4'b0000 gives s1=s2=s3=0 (input A routed).
REQ-013 FSM states: IDLE (gnt=0) and OWN (exactly one gnt bit set).
REQ-014 IDLE: if req!=0 at an edge, gnt SHALL become one-hot on the first requesting index found searching upward from ptr with wrap (ptr, ptr+1, ... mod 4); state->OWN; hold_cnt->0. Latency req-to-gnt = 1 cycle.
REQ-015 IDLE with req==0: state, gnt, ptr unchanged.
REQ-016 OWN, owner request low at edge: gnt->0, ptr->(owner+1) mod 4, hold_cnt->0, state->IDLE; no same-edge regrant (one dead cycle).
REQ-017 OWN, owner request high, hold_cnt<MAX_HOLD-1: keep grant, hold_cnt increments.
REQ-018 OWN, owner request high, hold_cnt==MAX_HOLD-1, another req bit high: grant SHALL move directly (no dead cycle) to next requester searching from owner+1 with wrap, excluding owner; ptr->(new owner+1) mod 4; hold_cnt->0.
REQ-019 OWN, owner request high, hold_cnt==MAX_HOLD-1, no other request: keep grant; hold_cnt saturates at MAX_HOLD-1.
REQ-020 Owner dropping request at same edge as limit reached SHALL follow REQ-016 (release takes precedence over rotation).
REQ-021 Requests of non-owners SHALL never change gnt before REQ-016/REQ-018 conditions occur.
REQ-022 MAX_HOLD=1: any other pending request SHALL rotate the grant every cycle.
REQ-023 gnt SHALL never have more than one bit set in any cycle, including reset exit.

Reset
REQ-024 rst high SHALL immediately (asynchronously) force gnt=0, s1=s2=s3=0, busy=0, hold_cnt=0, ptr=0, state=IDLE, including mid-grant.
REQ-025 After rst deasserts, first grant SHALL occur at the first edge with req!=0, searching from index 0.

Verification
REQ-026 Reset then req=4'b1010 held -> gnt=4'b0010 (s1=1) one edge later; after MAX_HOLD=4 cycles gnt=4'b1000 (s3=1), no gap cycle.
REQ-027 req=4'b0001 held alone 10 cycles -> gnt=4'b0001, s1=s2=s3=0, busy=1, hold_cnt saturates at 3.
REQ-028 Owner 2 drops req while req[3] high -> next edge gnt=0, following edge gnt=4'b1000.
REQ-029 req=4'b1111 held, MAX_HOLD=1 -> gnt sequence 0001,0010,0100,1000,0001 on successive edges; selects one-hot each cycle.
REQ-030 rst pulsed between edges while gnt=4'b0100 -> gnt and s2 low before next edge; after release, req=4'b1100 grants index 2.
REQ-031 Owner drops req on same edge hold_cnt reaches 3 with others pending -> gnt=0 for one cycle, then next requester granted.
